// File: rtl/reg_trace_streamer.sv
// Register-file write tracer: buffers {addr3, data3} write events in a FIFO and
// serializes each one as a 6-byte frame (HEADER, addr, data MSB..LSB) on a valid/ready byte stream.
module reg_trace_streamer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SKIP_ZERO = 1,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic [4:0]                   addr3,
    input  logic [31:0]                  data3,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         overflow,
    output logic [7:0]                   drop_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    input  logic                         clear_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, HDR, ADR, D3, D2, D1, D0} state_t;

    state_t          state, state_next;
    logic [36:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [36:0]     shadow;
    logic            capture, push, pop, drop;

    assign capture = write && !((SKIP_ZERO != 0) && (addr3 == 5'd0));
    assign pop     = (state == IDLE) && (fifo_count != '0);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push    = capture && ((fifo_count < CW'(DEPTH)) || pop);
    assign drop    = capture && !push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            shadow     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {addr3, data3};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                shadow <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_valid   = 1'b1;
        tx_data    = '0;
        case (state)
            IDLE: begin
                tx_valid = 1'b0;
                if (fifo_count != '0) state_next = HDR;
            end
            HDR: begin
                tx_data = HEADER;
                if (tx_ready) state_next = ADR;
            end
            ADR: begin
                tx_data = {3'b000, shadow[36:32]};
                if (tx_ready) state_next = D3;
            end
            D3: begin
                tx_data = shadow[31:24];
                if (tx_ready) state_next = D2;
            end
            D2: begin
                tx_data = shadow[23:16];
                if (tx_ready) state_next = D1;
            end
            D1: begin
                tx_data = shadow[15:8];
                if (tx_ready) state_next = D0;
            end
            D0: begin
                tx_data = shadow[7:0];
                if (tx_ready) state_next = IDLE;
            end
            default: begin
                tx_valid   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule
